// File: rtl/rom_shadow_loader_pkg.sv
// Shared definitions for the boot ROM shadow copy engine.
package rom_shadow_loader_pkg;

  // Copy engine FSM encoding (3-bit)
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ADDR  = 3'd1,
    ST_LATCH = 3'd2,
    ST_WRITE = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  // SRAM address that receives ROM byte 0
  localparam logic [18:0] SRAM_BASE_DEFAULT = 19'h78000;

endpackage

// File: rtl/rom_shadow_loader.sv
// Boot-time copy engine: walks the synchronous boot ROM, writes each byte to external SRAM
// through a req/ack handshake, keeps the CPU held until the copy finishes and sums the bytes.
module rom_shadow_loader
  import rom_shadow_loader_pkg::*;
#(
  parameter int unsigned          ROM_AW     = 15,
  parameter int unsigned          SRAM_AW    = 19,
  parameter logic [SRAM_AW-1:0]   SRAM_BASE  = SRAM_AW'(SRAM_BASE_DEFAULT),
  parameter bit                   AUTO_START = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  output logic [ROM_AW-1:0]  rom_a,
  input  logic [7:0]         rom_d,
  output logic [SRAM_AW-1:0] sram_a,
  output logic [7:0]         sram_d,
  output logic               sram_req,
  input  logic               sram_ack,
  output logic               busy,
  output logic               done,
  output logic               cpu_hold,
  output logic [15:0]        checksum
);

  state_e             r_state;
  logic [ROM_AW-1:0]  r_index;
  logic [SRAM_AW-1:0] r_sram_a;
  logic [7:0]         r_sram_d;
  logic               r_req;
  logic               r_busy;
  logic               r_done;
  logic [15:0]        r_checksum;

  logic               w_last;
  logic [SRAM_AW-1:0] w_sram_addr;

  // Last ROM address reached; the SRAM add wraps within SRAM_AW bits
  assign w_last      = (r_index == {ROM_AW{1'b1}});
  assign w_sram_addr = SRAM_BASE + SRAM_AW'(r_index);

  // Copy FSM with registered handshake, data and status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_index    <= '0;
      r_sram_a   <= SRAM_BASE;
      r_sram_d   <= 8'h00;
      r_req      <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_checksum <= 16'h0000;
    end else begin
      unique case (r_state)
        ST_IDLE, ST_DONE: begin
          // Leaving IDLE happens unconditionally when auto-starting; DONE always needs start
          if (start || (AUTO_START && (r_state == ST_IDLE))) begin
            r_index    <= '0;
            r_checksum <= 16'h0000;
            r_done     <= 1'b0;
            r_busy     <= 1'b1;
            r_state    <= ST_ADDR;
          end
        end
        // rom_a is already driven from the index; ROM returns data next cycle
        ST_ADDR: r_state <= ST_LATCH;
        ST_LATCH: begin
          r_sram_d   <= rom_d;
          r_sram_a   <= w_sram_addr;
          r_checksum <= r_checksum + {8'h00, rom_d};
          r_req      <= 1'b1;
          r_state    <= ST_WRITE;
        end
        ST_WRITE: begin
          // Ack only matters here, where req is guaranteed high
          if (sram_ack) begin
            r_req <= 1'b0;
            if (w_last) begin
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= ST_DONE;
            end else begin
              r_index <= r_index + 1'b1;
              r_state <= ST_ADDR;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign rom_a    = r_index;
  assign sram_a   = r_sram_a;
  assign sram_d   = r_sram_d;
  assign sram_req = r_req;
  assign busy     = r_busy;
  assign done     = r_done;
  assign cpu_hold = r_busy | ~r_done;
  assign checksum = r_checksum;

endmodule

// File: tb/tb_rom_shadow_loader.sv
// Scoreboard bench for rom_shadow_loader: expected SRAM writes are queued by the stimulus
// and popped by a monitor whenever a write is accepted (sram_req & sram_ack).
module tb_rom_shadow_loader;

  localparam int unsigned ROM_AW  = 4;
  localparam int unsigned SRAM_AW = 19;
  localparam logic [18:0] BASE    = 19'h78000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n = 1'b0;

  // Auto-start instance
  logic              start = 1'b0;
  logic [ROM_AW-1:0] rom_a;
  logic [7:0]        rom_d = 8'h00;
  logic [18:0]       sram_a;
  logic [7:0]        sram_d;
  logic              sram_req;
  logic              sram_ack = 1'b0;
  logic              busy, done, cpu_hold;
  logic [15:0]       checksum;

  // Manual-start instance
  logic              start2 = 1'b0;
  logic [ROM_AW-1:0] rom_a2;
  logic [7:0]        rom_d2 = 8'h00;
  logic [18:0]       sram_a2;
  logic [7:0]        sram_d2;
  logic              sram_req2;
  logic              sram_ack2;
  logic              busy2, done2, cpu_hold2;
  logic [15:0]       checksum2;

  rom_shadow_loader #(
    .ROM_AW(ROM_AW), .SRAM_AW(SRAM_AW), .SRAM_BASE(BASE), .AUTO_START(1'b1)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .rom_a(rom_a), .rom_d(rom_d),
    .sram_a(sram_a), .sram_d(sram_d), .sram_req(sram_req), .sram_ack(sram_ack),
    .busy(busy), .done(done), .cpu_hold(cpu_hold), .checksum(checksum)
  );

  rom_shadow_loader #(
    .ROM_AW(ROM_AW), .SRAM_AW(SRAM_AW), .SRAM_BASE(BASE), .AUTO_START(1'b0)
  ) u_dut_manual (
    .clk(clk), .rst_n(rst_n), .start(start2), .rom_a(rom_a2), .rom_d(rom_d2),
    .sram_a(sram_a2), .sram_d(sram_d2), .sram_req(sram_req2), .sram_ack(sram_ack2),
    .busy(busy2), .done(done2), .cpu_hold(cpu_hold2), .checksum(checksum2)
  );

  // ROM model: byte i = i+1, one-cycle registered read
  always @(posedge clk) begin
    rom_d  <= 8'(rom_a) + 8'd1;
    rom_d2 <= 8'(rom_a2) + 8'd1;
  end

  assign sram_ack2 = sram_req2;

  int          n_cmp = 0;
  int          n_fail = 0;
  logic [26:0] exp_q[$];
  logic        delay_en = 1'b0;
  logic        spurious_en = 1'b0;
  logic        start2_issued = 1'b0;
  int          req_cnt = 0;
  int          b3_cycles = 0;
  logic        prev_pending = 1'b0;
  logic [18:0] prev_a = '0;
  logic [7:0]  prev_d = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_run();
    for (int i = 0; i < 16; i++) exp_q.push_back({BASE + 19'(i), 8'(i + 1)});
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_rom_a"}, 32'(rom_a), 32'd0);
    check({tag, "_sram_a"}, 32'(sram_a), 32'(BASE));
    check({tag, "_sram_d"}, 32'(sram_d), 32'd0);
    check({tag, "_req"}, 32'(sram_req), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_hold"}, 32'(cpu_hold), 32'd1);
    check({tag, "_sum"}, 32'(checksum), 32'd0);
  endtask

  // Wait (bounded) for done, counting busy cycles on the way
  task automatic wait_done(input string tag, input int exp_busy);
    int bc = 0;
    int cyc = 0;
    logic seen = 1'b0;
    while (!seen && cyc < 1000) begin
      @(negedge clk);
      #2;
      cyc++;
      if (done) seen = 1'b1;
      else if (busy) bc++;
    end
    check({tag, "_done_seen"}, 32'(seen), 32'd1);
    check({tag, "_busy_cycles"}, 32'(bc), 32'(exp_busy));
    check({tag, "_checksum"}, 32'(checksum), 32'h0088);
    check({tag, "_hold_released"}, 32'(cpu_hold), 32'd0);
    check({tag, "_rom_a_last"}, 32'(rom_a), 32'd15);
  endtask

  // Pulse start from DONE and check the immediate clear of done/checksum
  task automatic restart(input string tag);
    @(negedge clk);
    #2 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    check({tag, "_done_cleared"}, 32'(done), 32'd0);
    check({tag, "_sum_cleared"}, 32'(checksum), 32'd0);
    check({tag, "_busy_set"}, 32'(busy), 32'd1);
  endtask

  // SRAM controller model: ack after a programmable wait, optional spurious acks
  always @(negedge clk) begin
    if (sram_req) begin
      if (req_cnt >= ((delay_en && sram_a == BASE + 19'd3) ? 5 : 0)) begin
        sram_ack = 1'b1;
        req_cnt  = 0;
      end else begin
        sram_ack = 1'b0;
        req_cnt++;
      end
    end else begin
      sram_ack = spurious_en;
      req_cnt  = 0;
    end
  end

  // Monitor: pops expected writes, checks stability while a request is pending
  always @(negedge clk) begin
    logic [26:0] e;
    #1;
    if (rst_n) begin
      if (sram_req && prev_pending) begin
        check("stable_addr", 32'(sram_a), 32'(prev_a));
        check("stable_data", 32'(sram_d), 32'(prev_d));
      end
      if (sram_req && delay_en && sram_a == BASE + 19'd3) b3_cycles++;
      if (sram_req && sram_ack) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, required no write",
                   sram_a, sram_d);
        end else begin
          e = exp_q.pop_front();
          check("write_addr", 32'(sram_a), 32'(e[26:8]));
          check("write_data", 32'(sram_d), 32'(e[7:0]));
        end
      end
      prev_pending = sram_req && !sram_ack;
      prev_a       = sram_a;
      prev_d       = sram_d;
    end else begin
      prev_pending = 1'b0;
    end
  end

  // Manual-start instance must stay idle with the CPU held until its start arrives
  always @(negedge clk) begin
    #1;
    if (!start2_issued) begin
      check("manual_no_req", 32'(sram_req2), 32'd0);
      check("manual_hold", 32'(cpu_hold2), 32'd1);
    end
  end

  initial begin
    int cyc;
    logic seen;

    // Reset state while held in reset
    repeat (2) @(negedge clk);
    #2 check_reset("reset");

    // Auto-start copy, ack in the same cycle as req
    push_run();
    #1 rst_n = 1'b1;
    wait_done("auto", 48);
    repeat (5) @(negedge clk);
    #2;
    check("auto_done_held", 32'(done), 32'd1);
    check("auto_no_wrap", 32'(rom_a), 32'd15);
    check("auto_sum_frozen", 32'(checksum), 32'h0088);

    // Recopy from DONE with byte 3 acked 5 cycles late and a start pulse while busy
    restart("delay");
    push_run();
    delay_en  = 1'b1;
    b3_cycles = 0;
    fork
      begin
        repeat (20) @(negedge clk);
        #3 start = 1'b1;
        @(negedge clk);
        #3 start = 1'b0;
      end
    join_none
    wait_done("delay", 53);
    check("byte3_req_cycles", 32'(b3_cycles), 32'd6);
    delay_en = 1'b0;

    // Spurious acks while no request is pending
    spurious_en = 1'b1;
    restart("spur");
    push_run();
    wait_done("spur", 48);
    spurious_en = 1'b0;

    // Asynchronous reset while fetching byte 7, then automatic restart
    restart("abort");
    push_run();
    cyc  = 0;
    seen = 1'b0;
    while (!seen && cyc < 200) begin
      @(negedge clk);
      #2;
      cyc++;
      if (rom_a == 4'd7 && busy && !sram_req) seen = 1'b1;
    end
    check("abort_byte7_seen", 32'(seen), 32'd1);
    rst_n = 1'b0;
    #1 check_reset("abort");
    exp_q.delete();
    push_run();
    @(negedge clk);
    #2 rst_n = 1'b1;
    wait_done("after_abort", 48);

    // Manual-start instance copies once started
    @(negedge clk);
    #3;
    start2_issued = 1'b1;
    start2 = 1'b1;
    @(negedge clk);
    #3 start2 = 1'b0;
    cyc  = 0;
    seen = 1'b0;
    while (!seen && cyc < 200) begin
      @(negedge clk);
      #2;
      cyc++;
      if (done2) seen = 1'b1;
    end
    check("manual_done", 32'(seen), 32'd1);
    check("manual_checksum", 32'(checksum2), 32'h0088);
    check("manual_hold_released", 32'(cpu_hold2), 32'd0);
    check("manual_last_addr", 32'(sram_a2), 32'(BASE + 19'd15));

    repeat (3) @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
